// File: rtl/serv_csr_pkg.sv
// serv_csr_pkg: shared constants for the bit-serial machine-mode CSR unit
package serv_csr_pkg;
  localparam logic [1:0] CSR_SOURCE_CSR = 2'b00;
  localparam logic [1:0] CSR_SOURCE_EXT = 2'b01;
  localparam logic [1:0] CSR_SOURCE_SET = 2'b10;
  localparam logic [1:0] CSR_SOURCE_CLR = 2'b11;
  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_MEI = 5'd11;
  localparam logic [4:0] CAUSE_EBREAK = 5'd3;
  localparam logic [4:0] CAUSE_ECALL = 5'd11;
  localparam logic [4:0] CAUSE_LD_MIS = 5'd4;
  localparam logic [4:0] CAUSE_ST_MIS = 5'd6;
  localparam logic [4:0] CAUSE_JMP_MIS = 5'd0;
  localparam logic [4:0] CAUSE_LOCAL_BASE = 5'd16;
  localparam int MSTATUS_MIE = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  // Implemented mie/mip bits: MSI, MTI, MEI plus the local lines from bit 16 up
  function automatic logic [31:0] irq_mask(int nlocal);
    return 32'h0000_0888 | (((32'd1 << nlocal) - 32'd1) << 16);
  endfunction
endpackage

// File: rtl/serv_csr_mirq_if.sv
// serv_csr_mirq_if: serial CSR access bus between decode/rf and the CSR unit
interface serv_csr_mirq_if;
  logic       i_mstatus_en;
  logic       i_mie_en;
  logic       i_mip_en;
  logic       i_mcause_en;
  logic [1:0] i_csr_source;
  logic       i_csr_d_sel;
  logic       i_csr_imm;
  logic       i_rs1;
  logic       i_rf_csr_out;
  logic       o_csr_in;
  logic       o_q;
  modport master (
    output i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en, i_csr_source,
           i_csr_d_sel, i_csr_imm, i_rs1, i_rf_csr_out,
    input  o_csr_in, o_q
  );
  modport slave (
    input  i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en, i_csr_source,
           i_csr_d_sel, i_csr_imm, i_rs1, i_rf_csr_out,
    output o_csr_in, o_q
  );
endinterface

// File: rtl/serv_csr_mirq_prio.sv
// serv_irq_prio: fixed-priority interrupt cause encoder, MEI > MSI > MTI > highest local
module serv_irq_prio
  import serv_csr_pkg::*;
(
  input  logic [31:0] pend,
  output logic [4:0]  code,
  output logic        valid
);
  logic [4:0] lcode;
  always_comb begin
    lcode = CAUSE_LOCAL_BASE;
    for (int k = int'(CAUSE_LOCAL_BASE); k < 32; k++) lcode = pend[k] ? 5'(k) : lcode;
    code = pend[CAUSE_MEI] ? CAUSE_MEI :
           pend[CAUSE_MSI] ? CAUSE_MSI :
           pend[CAUSE_MTI] ? CAUSE_MTI : lcode;
  end
  assign valid = |pend;
endmodule

// File: rtl/serv_csr_mirq.sv
// serv_csr_mirq: bit-serial mstatus/mie/mip/mcause with multi-source interrupt qualification
module serv_csr_mirq
  import serv_csr_pkg::*;
#(
  parameter int NLOCAL = 0,
  parameter int SYNC = 1,
  parameter int LW = (NLOCAL > 0) ? NLOCAL : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_init,
  input  logic          i_en,
  input  logic [4:0]    i_cnt,
  input  logic          i_cnt_done,
  input  logic          i_trap,
  input  logic          i_mret,
  input  logic          i_e_op,
  input  logic          i_ebreak,
  input  logic          i_mem_op,
  input  logic          i_mem_cmd,
  input  logic          i_msip,
  input  logic          i_mtip,
  input  logic          i_meip,
  input  logic [LW-1:0] i_lirq,
  serv_csr_mirq_if.slave bus,
  output logic          o_new_irq
);
  localparam logic [31:0] IRQ_MASK = irq_mask(NLOCAL);
  logic [31:0] sel, raw, s1, s2, mip, mie, pend, mie_we;
  logic        mstatus_mie, mstatus_mpie, mcause31, any_r, irq_any;
  logic        d, q, csr_in, trap_done;
  logic [4:0]  code, irq_code, irq_code_r, exc_code;
  assign sel = 32'd1 << i_cnt;
  assign raw = IRQ_MASK & {16'(i_lirq), 4'b0, i_meip, 3'b0, i_mtip, 3'b0, i_msip, 3'b0};
  always_ff @(posedge i_clk)
    if (i_rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  assign mip = (SYNC != 0) ? s2 : raw;
  assign pend = mip & mie & {32{mstatus_mie}};
  assign trap_done = i_trap & i_cnt_done;
  assign mie_we = {32{bus.i_mie_en & i_en & ~trap_done}} & sel & IRQ_MASK;
  serv_irq_prio u_prio (
    .pend  (pend),
    .code  (irq_code),
    .valid (irq_any)
  );
  always_comb begin
    d = bus.i_csr_d_sel ? bus.i_csr_imm : bus.i_rs1;
    q = bus.i_rf_csr_out
      | (bus.i_mstatus_en & ((sel[MSTATUS_MIE] & mstatus_mie) | (sel[MSTATUS_MPIE] & mstatus_mpie)
                             | sel[MSTATUS_MPP_LO] | sel[MSTATUS_MPP_HI]))
      | (bus.i_mie_en & |(mie & sel))
      | (bus.i_mip_en & |(mip & sel))
      | (bus.i_mcause_en & i_en & (|(code & sel[4:0]) | (sel[31] & mcause31)));
    csr_in = (bus.i_csr_source == CSR_SOURCE_EXT) ? d :
             (bus.i_csr_source == CSR_SOURCE_SET) ? (q | d) :
             (bus.i_csr_source == CSR_SOURCE_CLR) ? (q & ~d) : q;
    exc_code = i_e_op ? (i_ebreak ? CAUSE_EBREAK : CAUSE_ECALL) :
               i_mem_op ? (i_mem_cmd ? CAUSE_ST_MIS : CAUSE_LD_MIS) : CAUSE_JMP_MIS;
  end
  assign bus.o_q = q;
  assign bus.o_csr_in = csr_in;
  // any_r makes o_new_irq an edge detect so one level only raises a single trap
  always_ff @(posedge i_clk)
    if (i_rst) begin
      mie <= '0;
      mstatus_mie <= 1'b0;
      mstatus_mpie <= 1'b0;
      any_r <= 1'b0;
      o_new_irq <= 1'b0;
      irq_code_r <= '0;
    end else begin
      mie <= (mie & ~mie_we) | ({32{csr_in}} & mie_we);
      if (i_cnt_done && !i_init) begin
        any_r <= irq_any;
        o_new_irq <= irq_any && !any_r;
        irq_code_r <= irq_code;
      end
      if (trap_done) begin
        mstatus_mpie <= mstatus_mie;
        mstatus_mie <= 1'b0;
      end else if (i_mret && i_cnt_done) begin
        mstatus_mie <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (bus.i_mstatus_en && i_en) begin
        if (sel[MSTATUS_MIE]) mstatus_mie <= csr_in;
        if (sel[MSTATUS_MPIE]) mstatus_mpie <= csr_in;
      end
    end
  always_ff @(posedge i_clk)
    if (trap_done) begin
      mcause31 <= o_new_irq;
      code <= o_new_irq ? irq_code_r : exc_code;
    end else if (bus.i_mcause_en && i_en) begin
      code <= (code & ~sel[4:0]) | ({5{csr_in}} & sel[4:0]);
      if (sel[31]) mcause31 <= csr_in;
    end
endmodule

// File: tb/tb_serv_csr_mirq.sv
// tb_serv_csr_mirq: directed plus random instruction stream against a word-level CSR model
module tb_serv_csr_mirq;
  import serv_csr_pkg::*;
  localparam logic [31:0] MASK = 32'h000F_0888;
  logic clk = 0, rst = 1, init = 0, en = 0, cnt_done = 0, trap = 0, mret = 0;
  logic e_op = 0, ebreak = 0, mem_op = 0, mem_cmd = 0, msip = 0, mtip = 0, meip = 0, new_irq;
  logic [4:0] cnt = 0;
  logic [3:0] lirq = 0;
  int tests = 0, fails = 0;
  logic [31:0] m_mie, m_mip;
  logic m_ie, m_pie, m_any, m_new, m_c31;
  logic [4:0] m_code, m_irqc;
  serv_csr_mirq_if bus();
  serv_csr_mirq #(.NLOCAL(4), .SYNC(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_init(init), .i_en(en), .i_cnt(cnt), .i_cnt_done(cnt_done),
    .i_trap(trap), .i_mret(mret), .i_e_op(e_op), .i_ebreak(ebreak), .i_mem_op(mem_op),
    .i_mem_cmd(mem_cmd), .i_msip(msip), .i_mtip(mtip), .i_meip(meip), .i_lirq(lirq),
    .bus(bus), .o_new_irq(new_irq)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] prio(logic [31:0] p);
    if (p[11]) return 5'd11;
    if (p[3]) return 5'd3;
    if (p[7]) return 5'd7;
    for (int k = 31; k >= 16; k--) if (p[k]) return 5'(k);
    return 5'd0;
  endfunction

  function automatic logic [4:0] exc_code(logic [3:0] x);
    if (x[3]) return x[2] ? 5'd3 : 5'd11;
    if (x[1]) return x[0] ? 5'd6 : 5'd4;
    return 5'd0;
  endfunction

  function automatic logic [31:0] exp_read(int csr);
    case (csr)
      1: return 32'h1800 | (32'(m_ie) << 3) | (32'(m_pie) << 7);
      2: return m_mie;
      3: return m_mip;
      4: return {m_c31, 26'd0, m_code};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_mie = 0; m_ie = 0; m_pie = 0; m_any = 0; m_new = 0;
  endtask

  task automatic set_lines(input logic ms, input logic mt, input logic me, input logic [3:0] l);
    msip = ms; mtip = mt; meip = me; lirq = l;
    m_mip = (32'(ms) << 3) | (32'(mt) << 7) | (32'(me) << 11) | (32'(l) << 16);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic instr(input int csr, input logic [1:0] src, input logic [31:0] wd, input logic tr,
                       input logic mr, input logic [3:0] exc, input int rst_at,
                       output logic [31:0] rd, output logic [31:0] wo);
    logic dsel;
    dsel = 1'($urandom);
    bus.i_mstatus_en = (csr == 1); bus.i_mie_en = (csr == 2);
    bus.i_mip_en = (csr == 3); bus.i_mcause_en = (csr == 4);
    bus.i_csr_source = src; bus.i_csr_d_sel = dsel;
    {e_op, ebreak, mem_op, mem_cmd} = exc;
    trap = tr; en = 1;
    rd = '0; wo = '0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      cnt = 5'(k); cnt_done = (k == 31); mret = mr && (k == 31); rst = (k == rst_at);
      bus.i_csr_imm = dsel ? wd[k] : ~wd[k];
      bus.i_rs1 = dsel ? ~wd[k] : wd[k];
      #1;
      rd[k] = bus.o_q;
      wo[k] = bus.o_csr_in;
      @(posedge clk);
      if (k == rst_at) break;
    end
    #1;
    en = 0; cnt_done = 0; mret = 0; trap = 0; rst = 0;
    bus.i_mstatus_en = 0; bus.i_mie_en = 0; bus.i_mip_en = 0; bus.i_mcause_en = 0;
  endtask

  task automatic run(input int csr, input logic [1:0] src, input logic [31:0] wd, input logic tr,
                     input logic mr, input logic [3:0] exc, input string tag);
    logic [31:0] er, ew, rd, wo, pend;
    er = exp_read(csr);
    ew = (src == CSR_SOURCE_EXT) ? wd : (src == CSR_SOURCE_SET) ? (er | wd) :
         (src == CSR_SOURCE_CLR) ? (er & ~wd) : er;
    instr(csr, src, wd, tr, mr, exc, -1, rd, wo);
    check({tag, "_rd"}, rd, er);
    check({tag, "_wr"}, wo, ew);
    if (csr == 2) m_mie = ew & MASK;
    if (csr == 1) begin m_ie = ew[3]; m_pie = ew[7]; end
    if (csr == 4) begin m_code = ew[4:0]; m_c31 = ew[31]; end
    pend = m_mip & m_mie & {32{m_ie}};
    if (tr) begin
      m_c31 = m_new;
      m_code = m_new ? m_irqc : exc_code(exc);
      m_pie = m_ie;
      m_ie = 0;
    end else if (mr) begin
      m_ie = m_pie;
      m_pie = 1;
    end
    m_new = (pend != 0) && !m_any;
    m_any = (pend != 0);
    m_irqc = prio(pend);
    check({tag, "_irq"}, 32'(new_irq), 32'(m_new));
  endtask

  initial begin
    logic [31:0] rd, wo;
    bus.i_mstatus_en = 0; bus.i_mie_en = 0; bus.i_mip_en = 0; bus.i_mcause_en = 0;
    bus.i_csr_source = 0; bus.i_csr_d_sel = 0; bus.i_csr_imm = 0; bus.i_rs1 = 0; bus.i_rf_csr_out = 0;
    m_mip = 0; m_code = 0; m_c31 = 0; m_irqc = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    m_reset();
    check("rst_irq", 32'(new_irq), 32'd0);
    run(2, CSR_SOURCE_CSR, 0, 0, 0, 0, "mie_rst");
    run(1, CSR_SOURCE_CSR, 0, 0, 0, 0, "mstatus_rst");
    run(3, CSR_SOURCE_CSR, 0, 0, 0, 0, "mip_rst");
    run(1, CSR_SOURCE_EXT, 32'h8, 0, 0, 0, "mstatus_ie");
    run(2, CSR_SOURCE_SET, 32'h80, 0, 0, 0, "mie_mti");
    set_lines(0, 1, 0, 0);
    run(0, CSR_SOURCE_CSR, 0, 0, 0, 0, "wait_mti");
    run(0, CSR_SOURCE_CSR, 0, 1, 0, 0, "trap_mti");
    run(4, CSR_SOURCE_CSR, 0, 0, 0, 0, "mcause_mti");
    run(1, CSR_SOURCE_CSR, 0, 0, 0, 0, "mstatus_trap");
    run(0, CSR_SOURCE_CSR, 0, 0, 1, 0, "mret1");
    set_lines(1, 1, 1, 0);
    run(2, CSR_SOURCE_EXT, 32'h888, 0, 0, 0, "mie_all");
    run(0, CSR_SOURCE_CSR, 0, 1, 0, 0, "trap_mei");
    run(4, CSR_SOURCE_CSR, 0, 0, 0, 0, "mcause_mei");
    set_lines(0, 0, 0, 4'b1001);
    run(2, CSR_SOURCE_EXT, 32'h90000, 0, 0, 0, "mie_loc");
    run(0, CSR_SOURCE_CSR, 0, 0, 1, 0, "mret2");
    run(0, CSR_SOURCE_CSR, 0, 0, 0, 0, "wait_loc");
    run(0, CSR_SOURCE_CSR, 0, 1, 0, 0, "trap_loc");
    run(4, CSR_SOURCE_CSR, 0, 0, 0, 0, "mcause_loc");
    set_lines(0, 0, 0, 0);
    run(1, CSR_SOURCE_EXT, 32'h8, 0, 0, 0, "ie_ecall");
    run(0, CSR_SOURCE_CSR, 0, 1, 0, 4'b1000, "ecall");
    run(4, CSR_SOURCE_CSR, 0, 0, 0, 0, "mcause_ecall");
    run(1, CSR_SOURCE_EXT, 32'h8, 0, 0, 0, "ie_st");
    run(0, CSR_SOURCE_CSR, 0, 1, 0, 4'b0011, "st_mis");
    run(4, CSR_SOURCE_CSR, 0, 0, 0, 0, "mcause_st");
    run(0, CSR_SOURCE_CSR, 0, 0, 1, 0, "mret3");
    run(1, CSR_SOURCE_CSR, 0, 0, 0, 0, "mstatus_mret");
    run(2, CSR_SOURCE_SET, 32'h800, 0, 0, 0, "csrrs_mie");
    run(2, CSR_SOURCE_CLR, 32'h800, 0, 0, 0, "csrrc_mie");
    run(2, CSR_SOURCE_CSR, 0, 0, 0, 0, "mie_after");
    run(3, CSR_SOURCE_EXT, 32'hFFFF_FFFF, 0, 0, 0, "csrrw_mip");
    run(3, CSR_SOURCE_CSR, 0, 0, 0, 0, "mip_after");
    run(2, CSR_SOURCE_EXT, 32'h80, 0, 0, 0, "mie_hold");
    set_lines(0, 1, 0, 0);
    run(0, CSR_SOURCE_CSR, 0, 0, 0, 0, "hold1");
    run(0, CSR_SOURCE_CSR, 0, 0, 0, 0, "hold2");
    set_lines(0, 0, 0, 0);
    run(0, CSR_SOURCE_CSR, 0, 0, 0, 0, "drop");
    set_lines(0, 1, 0, 0);
    run(0, CSR_SOURCE_CSR, 0, 0, 0, 0, "rise");
    instr(2, CSR_SOURCE_EXT, 32'hFFFF_FFFF, 0, 0, 0, 12, rd, wo);
    m_reset();
    check("rst_mid_irq", 32'(new_irq), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    run(2, CSR_SOURCE_CSR, 0, 0, 0, 0, "mie_post_rst");
    for (int i = 0; i < 80; i++) begin
      int csr, r;
      if ($urandom_range(3) == 0)
        set_lines(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
      csr = $urandom_range(4);
      r = $urandom_range(5);
      run(csr, 2'($urandom), $urandom, r == 0, r == 1, 4'($urandom), "rnd");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serv_csr_mirq.md
Name: serv_csr_mirq

Overview:
- Bit-serial machine-mode CSR unit for the SERV core, one CSR bit per cycle, addressed by the bit counter.
- Generalises the single-timer-interrupt CSR block with three things it lacked:
  - a parametrised number of interrupt sources (MSI, MTI, MEI plus NLOCAL platform-local lines);
  - readable/writable mie, read-only mip, and full mstatus MIE/MPIE/MPP;
  - a 5-bit mcause code with a fixed priority encoder.
- Sits beside serv_state/serv_decode; feeds the rf CSR path and trap logic.

Parameters:
- NLOCAL, 0, number of local interrupt lines mapped to mie/mip/mcause bits 16..16+NLOCAL-1; legal range 0..16.
- SYNC, 1, 1 = two-flop synchroniser on i_msip/i_mtip/i_meip/i_lirq; 0 = lines used directly.
- LW, (NLOCAL>0 ? NLOCAL : 1), width of i_lirq; the port is ignored when NLOCAL=0.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_init  in  1  init phase of two-phase instruction.
- i_en  in  1  serial datapath active this cycle.
- i_cnt  in  5  bit index currently processed (0..31).
- i_cnt_done  in  1  last bit cycle (i_cnt==31).
- i_trap  in  1  trap being taken.
- i_mret  in  1  mret executing.
- i_e_op  in  1  ecall/ebreak.
- i_ebreak  in  1  ebreak.
- i_mem_op  in  1  misaligned load/store trap source.
- i_mem_cmd  in  1  1 = store.
- i_msip  in  1  software interrupt line.
- i_mtip  in  1  timer interrupt line.
- i_meip  in  1  external interrupt line.
- i_lirq  in  LW  local interrupt lines.
- i_mstatus_en  in  1  mstatus CSR access.
- i_mie_en  in  1  mie CSR access.
- i_mip_en  in  1  mip CSR access.
- i_mcause_en  in  1  mcause CSR access.
- i_csr_source  in  2  00 CSR, 01 EXT, 10 SET, 11 CLR.
- i_csr_d_sel  in  1  1 = immediate operand.
- i_csr_imm  in  1  serial immediate bit.
- i_rs1  in  1  serial rs1 bit.
- i_rf_csr_out  in  1  serial bit of rf-backed CSRs (mscratch/mepc/mtval/mtvec).
- o_csr_in  out  1  serial CSR write-data bit.
- o_q  out  1  serial CSR read bit.
- o_new_irq  out  1  interrupt to be taken by the next instruction.

Behaviour:
- Operand and write data:
  - d = i_csr_d_sel ? i_csr_imm : i_rs1.
  - o_csr_in = EXT: d; SET: q|d; CLR: q&~d; CSR: q. Combinational.
- Read bit q, ORed with i_rf_csr_out:
  - mstatus: MIE at cnt 3, MPIE at cnt 7, MPP at cnts 11 and 12 read constant 1.
  - mie/mip: bit k valid for k in {3, 7, 11, 16..16+NLOCAL-1}; all other bits read 0.
  - mcause: code[i_cnt] for cnt 0..4, bit31 at cnt 31, zero elsewhere. mcause reads are gated by i_en.
- mip: pending lines after optional synchroniser. Read-only; writes are ignored.
- mie bit k: written with o_csr_in when i_mie_en & i_en & i_cnt==k.
- Reset values:
  - mie = 0.
  - mstatus MIE = 0, MPIE = 0.
  - o_new_irq = 0; synchroniser flops = 0; pending-any register = 0.
  - mcause is not reset.
- Interrupt qualification:
  - pend = mip & mie & {MIE}, evaluated each cycle.
  - At i_cnt_done & !i_init: any_r <= |pend; o_new_irq <= |pend & !any_r. This is edge-detect, asserted for exactly one instruction.
  - irq_code is latched in the same cycle by priority: MEI(11) > MSI(3) > MTI(7) > local, highest local index first.
- Trap, at i_trap & i_cnt_done:
  - MPIE <= MIE; MIE <= 0; mcause bit31 <= o_new_irq.
  - code <= o_new_irq ? irq_code : exception code.
  - Exception codes: ebreak 3, ecall 11, misaligned load 4, misaligned store 6, misaligned jump 0.
- mret: MIE <= MPIE; MPIE <= 1.
- mstatus writes: MIE written at cnt 3, MPIE at cnt 7, when i_mstatus_en & i_en.
- mcause writes: code[i_cnt] <= o_csr_in at cnt 0..4; bit31 at cnt 31; requires i_mcause_en & i_en.
- Simultaneity:
  - Trap has priority over mret and over any CSR write in the same cycle.
  - An interrupt line dropping after o_new_irq is set does not cancel the trap.
- Reset mid-instruction: all reset state returns to its reset value on the next edge; partially written mie/mcause bits are lost.
- Latency:
  - Read and write path: 0 cycles (combinational serial bit).
  - Interrupt input to o_new_irq: SYNC*2 + wait to next i_cnt_done.

Decomposition:
- Shared package serv_csr_pkg:
  - CSR_SOURCE_* localparams.
  - Cause codes: CAUSE_MSI=3, MTI=7, MEI=11, EBREAK=3, ECALL=11, LD_MIS=4, ST_MIS=6, JMP_MIS=0, LOCAL_BASE=16.
  - mstatus bit indices.
- Sub-module serv_irq_prio: combinational priority encoder, pend vector -> 5-bit code plus valid.

Test Plan:
- Reset, then read mie/mstatus/mip with lines low -> all serial bits 0; MPP bits 11–12 read 1.
- Set MIE=1, mie[7]=1, raise i_mtip -> o_new_irq=1 after the next i_cnt_done; on trap, mcause=0x80000007, MIE=0, MPIE=1.
- i_meip, i_msip and i_mtip all enabled and raised together -> cause 11. With NLOCAL=4 and only i_lirq[3]|i_lirq[0] enabled -> cause 19.
- ecall trap -> mcause=11; misaligned store -> 6; mret afterwards -> MIE restored to 1, MPIE=1.
- csrrs mie with rs1=0x800, then csrrc with 0x800 -> mie[11] goes 1 then 0. csrrw mip with all ones -> mip unchanged.
- Line held high across two instructions -> o_new_irq high for one instruction only. Asserting i_rst mid-instruction -> mie and o_new_irq are 0 on the next cycle.
